// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : ROB/tag sizing and the ROB entry record shared by rename and ROB.
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int TAG_COUNT = 64;
  localparam int TAG_W     = $clog2(TAG_COUNT);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [TAG_W-1:0] tag_rd;
    logic [TAG_W-1:0] old_tag;
    logic             load_store;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reorder_buffer_if : allocate / complete / retire bundle of the ROB.
// Optional ROB_FLUSH_EN adds the flush strobe.  Rev 1.0
// ---------------------------------------------------------------------------
interface reorder_buffer_if
  import cpu_pkg::*;
#(
  parameter int NUM_ROB_LOG2  = ROB_IDX_W,
  parameter int NUM_TAGS_LOG2 = TAG_W
);
  logic                     alloc_valid;
  logic [NUM_TAGS_LOG2-1:0] alloc_tag_rd;
  logic [NUM_TAGS_LOG2-1:0] alloc_old_tag;
  logic                     alloc_load_store;
  logic [NUM_ROB_LOG2-1:0]  alloc_idx;
  logic                     rob_full;
  logic                     rob_empty;
  logic [1:0]               cmp_valid;
  logic [NUM_ROB_LOG2-1:0]  cmp_idx [0:1];
  logic [1:0]               retire_valid;
  logic [NUM_TAGS_LOG2-1:0] retire_tag [0:1];
`ifdef ROB_FLUSH_EN
  logic                     flush;
`endif

  modport master (
    output alloc_valid, alloc_tag_rd, alloc_old_tag, alloc_load_store,
    output cmp_valid, cmp_idx,
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    input  alloc_idx, rob_full, rob_empty, retire_valid, retire_tag
  );

  modport slave (
    input  alloc_valid, alloc_tag_rd, alloc_old_tag, alloc_load_store,
    input  cmp_valid, cmp_idx,
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    output alloc_idx, rob_full, rob_empty, retire_valid, retire_tag
  );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reorder_buffer : circular ROB, two completion ports, in-order 2-wide retire.
// Optional macro ROB_FLUSH_EN adds a flush input.  Rev 1.0
// ---------------------------------------------------------------------------
module reorder_buffer
  import cpu_pkg::*;
#(
  parameter int NUM_ROB       = ROB_DEPTH,
  parameter int NUM_TAGS      = TAG_COUNT,
  parameter int NUM_ROB_LOG2  = $clog2(NUM_ROB),
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS)
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);

  localparam int PTR_W = NUM_ROB_LOG2 + 1;

  rob_entry_t              entries [NUM_ROB];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W-1:0]        head_plus1;
  logic [NUM_ROB_LOG2-1:0] head_idx;
  logic [NUM_ROB_LOG2-1:0] head1_idx;
  logic [NUM_ROB_LOG2-1:0] tail_idx;
  logic                    full;
  logic                    empty;
  logic                    flush_now;
  logic                    ret0;
  logic                    ret1;
  logic                    accept;
  logic                    unused_fields;

  assign head_plus1 = head + PTR_W'(1);
  assign head_idx   = head[NUM_ROB_LOG2-1:0];
  assign head1_idx  = head_plus1[NUM_ROB_LOG2-1:0];
  assign tail_idx   = tail[NUM_ROB_LOG2-1:0];

  assign full  = (head_idx == tail_idx) && (head[NUM_ROB_LOG2] != tail[NUM_ROB_LOG2]);
  assign empty = (head == tail);

`ifdef ROB_FLUSH_EN
  assign flush_now = rob.flush;
`else
  assign flush_now = 1'b0;
`endif

  // Second slot may only retire behind the first: strict program order.
  assign ret0   = entries[head_idx].valid && entries[head_idx].done && !flush_now;
  assign ret1   = ret0 && entries[head1_idx].valid && entries[head1_idx].done;
  assign accept = rob.alloc_valid && !full;

  assign rob.rob_full  = full;
  assign rob.rob_empty = empty;
  assign rob.alloc_idx = tail_idx;

  assign rob.retire_valid[0] = ret0 && (entries[head_idx].old_tag != '0);
  assign rob.retire_valid[1] = ret1 && (entries[head1_idx].old_tag != '0);
  assign rob.retire_tag[0]   = ret0 ? entries[head_idx].old_tag  : '0;
  assign rob.retire_tag[1]   = ret1 ? entries[head1_idx].old_tag : '0;

  // tag_rd and load_store are held for downstream consumers, not read here.
  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < NUM_ROB; i++) begin
      unused_fields = unused_fields ^ (^{entries[i].tag_rd, entries[i].load_store});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < NUM_ROB; i++) begin
        entries[i] <= '0;
      end
    end else if (flush_now) begin
      tail <= head;
      for (int i = 0; i < NUM_ROB; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rob.cmp_valid[p] && entries[rob.cmp_idx[p]].valid) begin
          entries[rob.cmp_idx[p]].done <= 1'b1;
        end
      end
      // Retire clears come after completions so a retiring slot ends up empty.
      if (ret0) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
      end
      if (ret1) begin
        entries[head1_idx].valid <= 1'b0;
        entries[head1_idx].done  <= 1'b0;
      end
      if (accept) begin
        entries[tail_idx].valid      <= 1'b1;
        entries[tail_idx].done       <= 1'b0;
        entries[tail_idx].tag_rd     <= rob.alloc_tag_rd;
        entries[tail_idx].old_tag    <= rob.alloc_old_tag;
        entries[tail_idx].load_store <= rob.alloc_load_store;
        tail <= tail + PTR_W'(1);
      end
      head <= head + PTR_W'(ret0) + PTR_W'(ret1);
    end
  end

endmodule
`default_nettype wire
